// File: rtl/elevator_pkg.sv
// Shared types for the 5-floor car controller and the floor display decoder.
package elevator_pkg;

  localparam int FLOORS = 5;

  typedef logic [FLOORS-1:0] floor_oh_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } car_state_t;

  // Both masks assume f is one-hot: floors strictly above / strictly below f.
  function automatic floor_oh_t above_mask(input floor_oh_t f);
    return ~(f | (f - floor_oh_t'(1)));
  endfunction

  function automatic floor_oh_t below_mask(input floor_oh_t f);
    return f - floor_oh_t'(1);
  endfunction

  function automatic logic [2:0] status_of(input car_state_t s);
    return {s == MOVE_UP, s == MOVE_DOWN, s == DOOR};
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Up-counter with synchronous clear, enable and terminal-count flag; shared by
// the floor-travel and door-dwell timing.
module elev_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] tc_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = en && (count == tc_val);

endmodule

// File: rtl/elevator_car_ctrl.sv
// SCAN-order car controller for a 5-floor elevator. Defining ELEVATOR_ESTOP_EN
// adds an estop input that freezes timer, state and position while high.
//
// state     | meaning
// IDLE      | parked, no request ahead in either direction
// MOVE_UP   | travelling up, timer counts floor travel
// MOVE_DOWN | travelling down, timer counts floor travel
// DOOR      | door open at current floor, timer counts dwell
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int MOVE_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES = 150_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ELEVATOR_ESTOP_EN
  input  logic              estop,
`endif
  input  logic [FLOORS-1:0] call,
  output logic [FLOORS-1:0] floor_oh,
  output logic [FLOORS-1:0] pending,
  output logic              moving_up,
  output logic              moving_down,
  output logic              door_open
);

  localparam int MAX_CYCLES = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TW-1:0] MOVE_TC = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_TC = TW'(DOOR_CYCLES - 1);

  car_state_t state;
  logic       dir_up;
  logic       hold;
  logic       timer_clr;
  logic       timer_en;
  logic       timer_tc;
  logic       moving;
  logic       arrive_hit;
  logic       idle_hit;
  logic       door_restart;
  floor_oh_t  req;
  floor_oh_t  next_floor;
  floor_oh_t  clear;

`ifdef ELEVATOR_ESTOP_EN
  assign hold = estop;
`else
  assign hold = 1'b0;
`endif

  assign req          = pending | call;
  assign moving       = (state == MOVE_UP) || (state == MOVE_DOWN);
  assign next_floor   = (state == MOVE_UP) ? (floor_oh << 1) : (floor_oh >> 1);
  assign arrive_hit   = moving && timer_tc && |(req & next_floor);
  assign idle_hit     = (state == IDLE) && !hold && |(req & floor_oh);
  assign door_restart = (state == DOOR) && !hold && |(call & floor_oh);

  // The door floor is masked for the whole dwell so a repeat press only restarts
  // the timer and never leaves a stale request behind.
  always_comb begin
    clear = '0;
    if (arrive_hit)
      clear = next_floor;
    else if (idle_hit || (state == DOOR))
      clear = floor_oh;
  end

  // IDLE keeps the timer parked at zero so every move starts from a full count.
  assign timer_en  = !hold && (state != IDLE);
  assign timer_clr = !hold && ((state == IDLE) || timer_tc || door_restart);

  elev_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .tc_val ((state == DOOR) ? DOOR_TC : MOVE_TC),
    .tc     (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      floor_oh    <= floor_oh_t'(1);
      pending     <= '0;
      dir_up      <= 1'b1;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
    end else begin
      pending <= req & ~clear;
      case (state)
        IDLE: begin
          if (hold) begin
            state <= IDLE;
          end else if (idle_hit) begin
            state <= DOOR;
            {moving_up, moving_down, door_open} <= status_of(DOOR);
          end else if (dir_up && |(pending & above_mask(floor_oh))) begin
            state <= MOVE_UP;
            {moving_up, moving_down, door_open} <= status_of(MOVE_UP);
          end else if (!dir_up && |(pending & below_mask(floor_oh))) begin
            state <= MOVE_DOWN;
            {moving_up, moving_down, door_open} <= status_of(MOVE_DOWN);
          end else if (|(pending & above_mask(floor_oh))) begin
            state  <= MOVE_UP;
            dir_up <= 1'b1;
            {moving_up, moving_down, door_open} <= status_of(MOVE_UP);
          end else if (|(pending & below_mask(floor_oh))) begin
            state  <= MOVE_DOWN;
            dir_up <= 1'b0;
            {moving_up, moving_down, door_open} <= status_of(MOVE_DOWN);
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (timer_tc) begin
            floor_oh <= next_floor;
            if (arrive_hit) begin
              state <= DOOR;
              {moving_up, moving_down, door_open} <= status_of(DOOR);
            end else if ((state == MOVE_UP) && |(req & above_mask(next_floor))) begin
              state <= MOVE_UP;
            end else if ((state == MOVE_DOWN) && |(req & below_mask(next_floor))) begin
              state <= MOVE_DOWN;
            end else begin
              state <= IDLE;
              {moving_up, moving_down, door_open} <= status_of(IDLE);
            end
          end
        end
        DOOR: begin
          if (timer_tc && !door_restart) begin
            state <= IDLE;
            {moving_up, moving_down, door_open} <= status_of(IDLE);
          end
        end
        default: begin
          state <= IDLE;
          {moving_up, moving_down, door_open} <= status_of(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl with MOVE_CYCLES=4, DOOR_CYCLES=6.
module tb_elevator_car_ctrl;

  logic       clk;
  logic       rst_n;
  logic       estop;
  logic [4:0] call;
  logic [4:0] floor_oh;
  logic [4:0] pending;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;

  int checks = 0;
  int errors = 0;

  elevator_car_ctrl #(
    .MOVE_CYCLES (4),
    .DOOR_CYCLES (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ELEVATOR_ESTOP_EN
    .estop       (estop),
`endif
    .call        (call),
    .floor_oh    (floor_oh),
    .pending     (pending),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .door_open   (door_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    call  = 5'b0;
    estop = 1'b0;
    #12;
    chk("reset_floor", floor_oh, 5'b00001);
    chk("reset_pending", pending, 5'b00000);
    chk("reset_status", {2'b00, moving_up, moving_down, door_open}, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Single trip 0 -> 3
    call = 5'b01000;
    step(1);
    call = 5'b0;
    chk("trip_pending_e0", pending, 5'b01000);
    chk("trip_up_e0", {4'b0, moving_up}, 5'b0);
    step(1);
    chk("trip_up_e1", {4'b0, moving_up}, 5'b1);
    step(3);
    chk("trip_floor_e4", floor_oh, 5'b00001);
    step(1);
    chk("trip_floor_e5", floor_oh, 5'b00010);
    step(4);
    chk("trip_floor_e9", floor_oh, 5'b00100);
    step(4);
    chk("trip_floor_e13", floor_oh, 5'b01000);
    chk("trip_door_e13", {4'b0, door_open}, 5'b1);
    chk("trip_pending_e13", pending, 5'b00000);
    step(5);
    chk("trip_door_e18", {4'b0, door_open}, 5'b1);
    step(1);
    chk("trip_idle_e19", {2'b00, moving_up, moving_down, door_open}, 5'b00000);

    // Door restart at floor 2
    call = 5'b00100;
    step(1);
    call = 5'b0;
    step(1);
    chk("dr_down_e1", {4'b0, moving_down}, 5'b1);
    step(4);
    chk("dr_floor_e5", floor_oh, 5'b00100);
    chk("dr_door_e5", {4'b0, door_open}, 5'b1);
    step(4);
    call = 5'b00100;
    step(1);
    call = 5'b0;
    chk("dr_door_e10", {4'b0, door_open}, 5'b1);
    chk("dr_pending_e10", pending, 5'b00000);
    step(1);
    chk("dr_door_e11", {4'b0, door_open}, 5'b1);
    step(4);
    chk("dr_door_e15", {4'b0, door_open}, 5'b1);
    chk("dr_pending_e15", pending, 5'b00000);
    step(1);
    chk("dr_door_e16", {4'b0, door_open}, 5'b0);

    // Reset while between floors
    call = 5'b00001;
    step(1);
    call = 5'b0;
    step(1);
    chk("rm_down_e1", {4'b0, moving_down}, 5'b1);
    call = 5'b10000;
    step(1);
    call = 5'b0;
    chk("rm_pending_e2", pending, 5'b10001);
    step(3);
    chk("rm_floor_e5", floor_oh, 5'b00010);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("rm_floor", floor_oh, 5'b00001);
    chk("rm_pending", pending, 5'b00000);
    chk("rm_status", {2'b00, moving_up, moving_down, door_open}, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Direction preference: go up to 4 first, then back down to 0
    call = 5'b10000;
    step(1);
    call = 5'b0;
    step(1);
    call = 5'b00001;
    step(1);
    call = 5'b0;
    chk("dp_pending_e2", pending, 5'b10001);
    step(7);
    chk("dp_floor_e9", floor_oh, 5'b00100);
    chk("dp_up_e9", {4'b0, moving_up}, 5'b1);
    step(8);
    chk("dp_floor_e17", floor_oh, 5'b10000);
    chk("dp_door_e17", {4'b0, door_open}, 5'b1);
    chk("dp_pending_e17", pending, 5'b00001);
    step(6);
    chk("dp_idle_e23", {2'b00, moving_up, moving_down, door_open}, 5'b00000);
    step(1);
    chk("dp_down_e24", {4'b0, moving_down}, 5'b1);
    step(15);
    chk("dp_floor_e39", floor_oh, 5'b00010);
    step(1);
    chk("dp_floor_e40", floor_oh, 5'b00001);
    chk("dp_door_e40", {4'b0, door_open}, 5'b1);
    chk("dp_pending_e40", pending, 5'b00000);
    step(6);
    chk("dp_door_e46", {4'b0, door_open}, 5'b0);

`ifdef ELEVATOR_ESTOP_EN
    // Estop hold of 10 edges at move-timer count 2
    call = 5'b00010;
    step(1);
    call = 5'b0;
    step(1);
    chk("es_up_e1", {4'b0, moving_up}, 5'b1);
    step(2);
    estop = 1'b1;
    step(2);
    call = 5'b10000;
    step(1);
    call = 5'b0;
    chk("es_pending_e6", pending, 5'b10010);
    chk("es_floor_e6", floor_oh, 5'b00001);
    step(7);
    chk("es_floor_e13", floor_oh, 5'b00001);
    chk("es_up_e13", {4'b0, moving_up}, 5'b1);
    estop = 1'b0;
    step(1);
    chk("es_floor_e14", floor_oh, 5'b00001);
    step(1);
    chk("es_floor_e15", floor_oh, 5'b00010);
    chk("es_door_e15", {4'b0, door_open}, 5'b1);
    chk("es_pending_e15", pending, 5'b10000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
